// File: rtl/pconv_pkg.sv
// Shared constants and parameter sanity helpers for the pointwise convolution unit.
package pconv_pkg;

  localparam int unsigned PCONV_LAT = 4;
  localparam int unsigned SHIFT_W   = 5;
  localparam int unsigned ACC_W_DEF = 32;

  // True when ACC_W can hold a full group of worst-case products without wrapping.
  function automatic bit acc_w_ok(input int unsigned n, input int unsigned lanes,
                                  input int unsigned beats, input int unsigned acc_w);
    return acc_w >= (2 * n + $clog2(lanes * beats));
  endfunction

endpackage

// File: rtl/pconv_postproc.sv
// Combinational bias, optional rounding, arithmetic shift, ReLU and clip to N bits.
module pconv_postproc
  import pconv_pkg::*;
#(
  parameter int unsigned N     = 16,
  parameter int unsigned ACC_W = ACC_W_DEF,
  parameter int          MAX   = 127,
  parameter bit          ROUND = 1'b0
) (
  input  logic signed [ACC_W-1:0]   acc_i,
  input  logic signed [ACC_W-1:0]   bias_i,
  input  logic        [SHIFT_W-1:0] shift_i,
  input  logic                      relu_en_i,
  output logic        [N-1:0]       dout_o,
  output logic                      sat_o
);

  // Two guard bits so bias and rounding additions can never wrap.
  localparam int unsigned VW = ACC_W + 2;
  localparam logic signed [VW-1:0] Hi = VW'(MAX);
  localparam logic signed [VW-1:0] Lo = VW'(-(MAX + 1));

  logic signed [VW-1:0] v;
  logic signed [VW-1:0] lo;

  always_comb begin
    dout_o = '0;
    sat_o  = 1'b0;
    v      = VW'(acc_i) + VW'(bias_i);
    if (ROUND && (shift_i != '0)) begin
      v = v + (VW'(1) << (shift_i - 1'b1));
    end
    v = v >>> shift_i;
    if (relu_en_i && (v < 0)) begin
      v = '0;
    end
    lo = relu_en_i ? '0 : Lo;
    if (v > Hi) begin
      dout_o = Hi[N-1:0];
      sat_o  = 1'b1;
    end else if (v < lo) begin
      dout_o = lo[N-1:0];
      sat_o  = 1'b1;
    end else begin
      dout_o = v[N-1:0];
    end
  end

endmodule

// File: rtl/pconv_accum_unit.sv
// Pipelined 1x1 convolution for one output channel: multiply, lane sum, accumulate, post-process.
module pconv_accum_unit
  import pconv_pkg::*;
#(
  parameter int unsigned N     = 16,
  parameter int unsigned LANES = 4,
  parameter int unsigned BEATS = 4,
  parameter int unsigned ACC_W = ACC_W_DEF,
  parameter int          MAX   = 127,
  parameter bit          ROUND = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 in_vld,
  input  logic [LANES*N-1:0]   input_din,
  input  logic [LANES*N-1:0]   weight_din,
  input  logic [ACC_W-1:0]     bias_din,
  input  logic [SHIFT_W-1:0]   shift_din,
  input  logic                 relu_en,
  output logic [N-1:0]         conv_dout,
  output logic                 conv_dout_vld,
  output logic                 conv_dout_sat,
  output logic                 busy
);

  localparam int unsigned PW   = 2 * N;
  localparam int unsigned CntW = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam bit AccWOk = acc_w_ok(N, LANES, BEATS, ACC_W);
  localparam bit MaxOk  = (MAX >= 0) && (MAX < (1 << (N - 1)));

  always_ff @(posedge clk) begin
    assert (AccWOk && MaxOk) else $error("pconv_accum_unit: ACC_W or MAX out of range");
  end

  logic [CntW-1:0]          cnt_q, cnt_d;
  logic                     first, last;
  // vld_q[0..2] track S1..S3; vld_q[3] is the registered result strobe.
  logic [PCONV_LAT-1:0]     vld_q, vld_d;

  logic signed [PW-1:0]     prod [LANES];
  logic signed [PW-1:0]     s1_prod_q [LANES];
  logic                     s1_first_q, s1_last_q;
  logic [ACC_W-1:0]         s1_bias_q;
  logic [SHIFT_W-1:0]       s1_shift_q;
  logic                     s1_relu_q;

  logic signed [ACC_W-1:0]  lane_sum;
  logic signed [ACC_W-1:0]  s2_sum_q;
  logic                     s2_first_q, s2_last_q;
  logic [ACC_W-1:0]         s2_bias_q;
  logic [SHIFT_W-1:0]       s2_shift_q;
  logic                     s2_relu_q;

  logic signed [ACC_W-1:0]  acc_q;
  logic [ACC_W-1:0]         s3_bias_q;
  logic [SHIFT_W-1:0]       s3_shift_q;
  logic                     s3_relu_q;

  logic [N-1:0]             pp_dout, dout_q;
  logic                     pp_sat, sat_q;

  assign first = (cnt_q == '0);
  assign last  = (cnt_q == CntW'(BEATS - 1));

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    assign prod[i] = PW'($signed(input_din[i*N +: N])) * PW'($signed(weight_din[i*N +: N]));
  end

  always_comb begin
    lane_sum = '0;
    for (int i = 0; i < LANES; i++) begin
      lane_sum = lane_sum + ACC_W'(s1_prod_q[i]);
    end
  end

  // clear wins over in_vld and drops every in-flight stage.
  always_comb begin
    cnt_d = cnt_q;
    vld_d = '0;
    if (clear) begin
      cnt_d = '0;
    end else begin
      vld_d[0] = in_vld;
      vld_d[1] = vld_q[0];
      vld_d[2] = vld_q[1] & s2_last_q;
      vld_d[3] = vld_q[2];
      if (in_vld) begin
        cnt_d = last ? '0 : cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q      <= '0;
      vld_q      <= '0;
      s1_prod_q  <= '{default: '0};
      s1_first_q <= 1'b0;
      s1_last_q  <= 1'b0;
      s1_bias_q  <= '0;
      s1_shift_q <= '0;
      s1_relu_q  <= 1'b0;
      s2_sum_q   <= '0;
      s2_first_q <= 1'b0;
      s2_last_q  <= 1'b0;
      s2_bias_q  <= '0;
      s2_shift_q <= '0;
      s2_relu_q  <= 1'b0;
      acc_q      <= '0;
      s3_bias_q  <= '0;
      s3_shift_q <= '0;
      s3_relu_q  <= 1'b0;
      dout_q     <= '0;
      sat_q      <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      vld_q <= vld_d;
      if (in_vld && !clear) begin
        s1_prod_q  <= prod;
        s1_first_q <= first;
        s1_last_q  <= last;
      end
      // Sideband is taken only from the last beat and follows it down the pipe.
      if (in_vld && !clear && last) begin
        s1_bias_q  <= bias_din;
        s1_shift_q <= shift_din;
        s1_relu_q  <= relu_en;
      end
      if (vld_q[0]) begin
        s2_sum_q   <= lane_sum;
        s2_first_q <= s1_first_q;
        s2_last_q  <= s1_last_q;
      end
      if (vld_q[0] && s1_last_q) begin
        s2_bias_q  <= s1_bias_q;
        s2_shift_q <= s1_shift_q;
        s2_relu_q  <= s1_relu_q;
      end
      if (vld_q[1]) begin
        acc_q <= s2_first_q ? s2_sum_q : acc_q + s2_sum_q;
      end
      if (vld_q[1] && s2_last_q) begin
        s3_bias_q  <= s2_bias_q;
        s3_shift_q <= s2_shift_q;
        s3_relu_q  <= s2_relu_q;
      end
      if (vld_q[2]) begin
        dout_q <= pp_dout;
        sat_q  <= pp_sat;
      end
    end
  end

  pconv_postproc #(
    .N    (N),
    .ACC_W(ACC_W),
    .MAX  (MAX),
    .ROUND(ROUND)
  ) u_postproc (
    .acc_i    (acc_q),
    .bias_i   (s3_bias_q),
    .shift_i  (s3_shift_q),
    .relu_en_i(s3_relu_q),
    .dout_o   (pp_dout),
    .sat_o    (pp_sat)
  );

  assign conv_dout     = dout_q;
  assign conv_dout_vld = vld_q[3];
  assign conv_dout_sat = sat_q;
  assign busy          = (cnt_q != '0) | (|vld_q);

endmodule

// File: tb/tb_pconv_accum_unit.sv
// Bench for pconv_accum_unit: directed vector table, corner sequences and randomized groups.
module tb_pconv_accum_unit;

  localparam int unsigned N     = 16;
  localparam int unsigned LANES = 4;
  localparam int unsigned BEATS = 2;
  localparam int unsigned ACC_W = 36;
  localparam int          MAX   = 127;

  logic               clk = 1'b0;
  logic               rst, clear, in_vld, relu_en;
  logic [LANES*N-1:0] input_din, weight_din;
  logic [ACC_W-1:0]   bias_din;
  logic [4:0]         shift_din;
  logic [N-1:0]       dout0, dout1;
  logic               vld0, vld1, sat0, sat1, busy0, busy1;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  pconv_accum_unit #(
    .N(N), .LANES(LANES), .BEATS(BEATS), .ACC_W(ACC_W), .MAX(MAX), .ROUND(1'b0)
  ) dut (
    .clk(clk), .rst(rst), .clear(clear), .in_vld(in_vld), .input_din(input_din),
    .weight_din(weight_din), .bias_din(bias_din), .shift_din(shift_din), .relu_en(relu_en),
    .conv_dout(dout0), .conv_dout_vld(vld0), .conv_dout_sat(sat0), .busy(busy0)
  );

  pconv_accum_unit #(
    .N(N), .LANES(LANES), .BEATS(BEATS), .ACC_W(ACC_W), .MAX(MAX), .ROUND(1'b1)
  ) dut_rnd (
    .clk(clk), .rst(rst), .clear(clear), .in_vld(in_vld), .input_din(input_din),
    .weight_din(weight_din), .bias_din(bias_din), .shift_din(shift_din), .relu_en(relu_en),
    .conv_dout(dout1), .conv_dout_vld(vld1), .conv_dout_sat(sat1), .busy(busy1)
  );

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input longint act, input longint req);
    n_total++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    longint dout;
    bit     sat;
    int     due;
  } exp_t;

  exp_t   q0[$], q1[$];
  longint grp_acc = 0;
  int     grp_n = 0;

  function automatic longint wrap(input longint x);
    longint t;
    t = x <<< (64 - ACC_W);
    return t >>> (64 - ACC_W);
  endfunction

  function automatic longint dot(input logic [LANES*N-1:0] a, input logic [LANES*N-1:0] w);
    longint s = 0;
    for (int i = 0; i < LANES; i++)
      s += longint'($signed(a[i*N +: N])) * longint'($signed(w[i*N +: N]));
    return s;
  endfunction

  function automatic void post(input longint acc, input longint bias, input int sh,
                               input bit relu, input bit rnd, output longint d, output bit s);
    longint v, lo;
    v = acc + bias;
    if (rnd && sh > 0) v += longint'(1) << (sh - 1);
    v = v >>> sh;
    if (relu && v < 0) v = 0;
    lo = relu ? 0 : -(MAX + 1);
    s = 1'b1;
    if (v > MAX) d = MAX;
    else if (v < lo) d = lo;
    else begin
      d = v;
      s = 1'b0;
    end
  endfunction

  function automatic void flush(input int after);
    while (q0.size() != 0 && q0[q0.size()-1].due > after) void'(q0.pop_back());
    while (q1.size() != 0 && q1[q1.size()-1].due > after) void'(q1.pop_back());
  endfunction

  function automatic logic [LANES*N-1:0] bcast(input int v);
    logic [LANES*N-1:0] r;
    for (int i = 0; i < LANES; i++) r[i*N +: N] = 16'(v);
    return r;
  endfunction

  // ---------------- output monitors ----------------
  int     n_out0 = 0;
  longint last_d0 = 0;
  exp_t   e0, e1;

  always @(negedge clk) if (!rst) begin
    if (q0.size() != 0 && q0[0].due < cyc) begin
      check("r0 missing result", cyc, q0[0].due);
      void'(q0.pop_front());
    end
    if (vld0) begin
      n_out0++;
      last_d0 = longint'($signed(dout0));
      if (q0.size() == 0) check("r0 spurious vld", vld0, 0);
      else begin
        e0 = q0.pop_front();
        check("r0 dout", longint'($signed(dout0)), e0.dout);
        check("r0 sat", sat0, e0.sat);
        check("r0 latency", cyc, e0.due);
      end
    end
  end

  always @(negedge clk) if (!rst) begin
    if (q1.size() != 0 && q1[0].due < cyc) begin
      check("r1 missing result", cyc, q1[0].due);
      void'(q1.pop_front());
    end
    if (vld1) begin
      if (q1.size() == 0) check("r1 spurious vld", vld1, 0);
      else begin
        e1 = q1.pop_front();
        check("r1 dout", longint'($signed(dout1)), e1.dout);
        check("r1 sat", sat1, e1.sat);
        check("r1 latency", cyc, e1.due);
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic drive(input logic [LANES*N-1:0] a, input logic [LANES*N-1:0] w,
                       input longint bias, input int sh, input bit relu,
                       input bit vld, input bit clr);
    exp_t x;
    input_din  = a;
    weight_din = w;
    bias_din   = ACC_W'(bias);
    shift_din  = 5'(sh);
    relu_en    = relu;
    in_vld     = vld;
    clear      = clr;
    if (clr) begin
      grp_n = 0;
      flush(cyc);
    end else if (vld) begin
      grp_acc = (grp_n == 0) ? wrap(dot(a, w)) : wrap(grp_acc + dot(a, w));
      grp_n++;
      if (grp_n == BEATS) begin
        x.due = cyc + 4;
        post(grp_acc, bias, sh, relu, 1'b0, x.dout, x.sat);
        q0.push_back(x);
        post(grp_acc, bias, sh, relu, 1'b1, x.dout, x.sat);
        q1.push_back(x);
        grp_n = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [LANES*N-1:0] a, input logic [LANES*N-1:0] w,
                      input longint bias, input int sh, input bit relu);
    drive(a, w, bias, sh, relu, 1'b1, 1'b0);
  endtask

  task automatic idle(input int n);
    repeat (n) drive('0, '0, 0, 0, 1'b0, 1'b0, 1'b0);
  endtask

  function automatic logic [LANES*N-1:0] rand_lanes();
    logic [LANES*N-1:0] r;
    for (int i = 0; i < LANES; i++)
      r[i*N +: N] = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 16) - 8);
    return r;
  endfunction

  // ---------------- directed vector table ----------------
  typedef struct {
    int     a;
    int     w;
    longint bias;
    int     sh;
    bit     relu;
    bit     rnd;
    longint dout;
    bit     sat;
  } vec_t;

  vec_t tbl[14];

  initial begin
    int o;
    logic vs, ss;
    logic [N-1:0] ds;

    tbl[0]  = '{2, 3, 0, 0, 1'b0, 1'b0, 48, 1'b0};
    tbl[1]  = '{2, 3, 1000, 3, 1'b0, 1'b0, 127, 1'b1};
    tbl[2]  = '{2, 3, 1000, 4, 1'b0, 1'b0, 65, 1'b0};
    tbl[3]  = '{2, 3, 1000, 4, 1'b0, 1'b1, 66, 1'b0};
    tbl[4]  = '{-2, 3, 0, 0, 1'b0, 1'b0, -48, 1'b0};
    tbl[5]  = '{-2, 3, 0, 0, 1'b1, 1'b0, 0, 1'b0};
    tbl[6]  = '{-2, 3, -200, 0, 1'b0, 1'b0, -128, 1'b1};
    tbl[7]  = '{2, 3, 79, 0, 1'b0, 1'b0, 127, 1'b0};
    tbl[8]  = '{-2, 3, -80, 0, 1'b0, 1'b0, -128, 1'b0};
    tbl[9]  = '{2, 3, 80, 0, 1'b0, 1'b0, 127, 1'b1};
    tbl[10] = '{2, 3, 1000, 0, 1'b1, 1'b0, 127, 1'b1};
    tbl[11] = '{-2, 3, -81, 0, 1'b0, 1'b1, -128, 1'b1};
    tbl[12] = '{2, 3, -1, 1, 1'b0, 1'b1, 24, 1'b0};
    tbl[13] = '{-2, 3, -3, 1, 1'b0, 1'b1, -25, 1'b0};

    rst = 1'b0; clear = 1'b0; in_vld = 1'b0; relu_en = 1'b0;
    input_din = '0; weight_din = '0; bias_din = '0; shift_din = '0;
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset dout", dout0, 0);
    check("reset vld", vld0, 0);
    check("reset sat", sat0, 0);
    check("reset busy", busy0, 0);
    rst = 1'b0;
    idle(1);

    // Directed vectors; first-beat sideband is deliberately junk.
    for (int i = 0; i < 14; i++) begin
      beat(bcast(tbl[i].a), bcast(tbl[i].w), 555, 7, 1'b1);
      check($sformatf("tbl%0d busy mid-group", i), busy0, 1);
      beat(bcast(tbl[i].a), bcast(tbl[i].w), tbl[i].bias, tbl[i].sh, tbl[i].relu);
      idle(3);
      vs = tbl[i].rnd ? vld1 : vld0;
      ds = tbl[i].rnd ? dout1 : dout0;
      ss = tbl[i].rnd ? sat1 : sat0;
      check($sformatf("tbl%0d vld at +4", i), vs, 1);
      check($sformatf("tbl%0d dout", i), longint'($signed(ds)), tbl[i].dout);
      check($sformatf("tbl%0d sat", i), ss, tbl[i].sat);
    end

    // Back-to-back groups 48 then 24.
    idle(6);
    o = n_out0;
    beat(bcast(2), bcast(3), 0, 0, 1'b0);
    beat(bcast(2), bcast(3), 0, 0, 1'b0);
    beat(bcast(1), bcast(3), 0, 0, 1'b0);
    beat(bcast(1), bcast(3), 0, 0, 1'b0);
    idle(6);
    check("b2b result count", n_out0 - o, 2);
    check("b2b second value", last_d0, 24);

    // clear aborts a partial group and ignores its own in_vld.
    o = n_out0;
    beat(bcast(5), bcast(5), 0, 0, 1'b0);
    drive(bcast(7), bcast(7), 0, 0, 1'b0, 1'b1, 1'b1);
    check("clear busy", busy0, 0);
    check("clear vld", vld0, 0);
    beat(bcast(2), bcast(3), 0, 0, 1'b0);
    beat(bcast(2), bcast(3), 0, 0, 1'b0);
    idle(6);
    check("clear result count", n_out0 - o, 1);
    check("clear value", last_d0, 48);

    // Reset two cycles after a last beat.
    beat(bcast(2), bcast(3), 0, 0, 1'b0);
    beat(bcast(2), bcast(3), 0, 0, 1'b0);
    idle(1);
    rst = 1'b1;
    grp_n = 0;
    flush(cyc - 1);
    #1;
    check("rst dout", dout0, 0);
    check("rst sat", sat0, 0);
    check("rst busy", busy0, 0);
    check("rst busy r1", busy1, 0);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("rst vld hold %0d", k), vld0, 0);
    end
    rst = 1'b0;
    o = n_out0;
    beat(bcast(2), bcast(3), 0, 0, 1'b0);
    beat(bcast(2), bcast(3), 0, 0, 1'b0);
    idle(3);
    check("post-rst vld at +4", vld0, 1);
    check("post-rst dout", longint'($signed(dout0)), 48);
    idle(3);
    check("post-rst result count", n_out0 - o, 1);

    // Randomized groups with gaps and varying sideband.
    for (int g = 0; g < 60; g++) begin
      for (int b = 0; b < BEATS; b++) begin
        if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
        beat(rand_lanes(), rand_lanes(),
             ($urandom_range(0, 3) == 0) ? longint'($signed($urandom))
                                         : longint'($urandom_range(0, 4000)) - 2000,
             ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 4)),
             1'($urandom_range(0, 1)));
      end
    end
    idle(8);
    check("r0 leftover expected", q0.size(), 0);
    check("r1 leftover expected", q1.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
